async_tx_pacer: RTL and testbench

Source-domain feeder for the slow-to-fast single-word CDC (`async_dmux`). It accepts words on a valid/ready stream, buffers them in a small FIFO, and re-issues each word as a single-cycle `out_val` pulse. Pulses are spaced by a guaranteed idle gap, and `out_data` is held stable between pulses. This lets the CDC, which cannot take continuous transfers, see every word exactly once.

---
 rtl/async_tx_pacer.sv | 66 ++++++
 tb/tb_async_tx_pacer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/async_tx_pacer.sv
// async_tx_pacer: FIFO-buffered feeder that re-issues each word as a spaced single-cycle pulse for a slow-to-fast CDC
module async_tx_pacer #(
    parameter int W = 32,
    parameter int DEPTH = 4,
    parameter int GAP = 3,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_val,
    output logic          in_rdy,
    input  logic [W-1:0]  in_data,
    output logic          out_val,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] count,
    output logic          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP + 1);
    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;
    state_t        state;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [GW-1:0] gap_cnt;
    logic          push, pop;
    assign in_rdy = count != CW'(DEPTH);
    assign busy   = (state != IDLE) || (count != '0);
    assign push   = in_val && in_rdy;
    assign pop    = (count != '0) && (state == IDLE || (state == HOLD && gap_cnt == '0));
    // Storage array carries no reset; pointers and occupancy define which entries are live.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;
    // Pointers wrap naturally at DEPTH; occupancy only moves when push and pop differ.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
        end
    // Pulse sequencer: a pop loads out_data and enters SEND, then GAP idle cycles follow in HOLD.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state    <= IDLE;
            out_val  <= 1'b0;
            out_data <= '0;
            gap_cnt  <= '0;
        end else begin
            out_val <= pop;
            if (pop) out_data <= mem[rd_ptr];
            case (state)
                IDLE: state <= pop ? SEND : IDLE;
                SEND: begin
                    state   <= HOLD;
                    gap_cnt <= GW'(GAP - 1);
                end
                HOLD:
                    if (gap_cnt == '0) state <= pop ? SEND : IDLE;
                    else gap_cnt <= gap_cnt - GW'(1);
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_async_tx_pacer.sv
// tb_async_tx_pacer: directed checks of pacing, ordering, backpressure and reset for async_tx_pacer
module tb_async_tx_pacer;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        a_in_val = 1'b0, a_in_rdy, a_out_val, a_busy;
    logic [31:0] a_in_data = '0, a_out_data;
    logic [2:0]  a_count;
    logic        b_in_val = 1'b0, b_in_rdy, b_out_val, b_busy;
    logic [31:0] b_in_data = '0, b_out_data;
    logic [1:0]  b_count;
    int          n_cmp = 0, n_err = 0, cyc = 0;
    logic [31:0] qa_d[$], qb_d[$], exp_q[$];
    int          qa_c[$], qb_c[$];

    async_tx_pacer dut_a (
        .clk(clk), .rstn(rstn), .in_val(a_in_val), .in_rdy(a_in_rdy), .in_data(a_in_data),
        .out_val(a_out_val), .out_data(a_out_data), .count(a_count), .busy(a_busy)
    );

    async_tx_pacer #(.W(32), .DEPTH(2), .GAP(1)) dut_b (
        .clk(clk), .rstn(rstn), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_data(b_in_data),
        .out_val(b_out_val), .out_data(b_out_data), .count(b_count), .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (a_out_val) begin
            qa_d.push_back(a_out_data);
            qa_c.push_back(cyc);
        end
        if (b_out_val) begin
            qb_d.push_back(b_out_data);
            qb_c.push_back(cyc);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_pulses(input string tag, input bit sel_b, input int sp, input int first);
        logic [31:0] d[$];
        int c[$];
        int k = 0;
        while (k < 400 && (sel_b ? qb_d.size() : qa_d.size()) < exp_q.size()) begin
            step();
            k++;
        end
        step(8);
        if (sel_b) begin
            d = qb_d;
            c = qb_c;
        end else begin
            d = qa_d;
            c = qa_c;
        end
        chk($sformatf("%s_npulses", tag), d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < d.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), d[i], exp_q[i]);
            if (i == 0) chk($sformatf("%s_first_cyc", tag), c[0], first);
            else chk($sformatf("%s_space%0d", tag, i), c[i] - c[i-1], sp);
        end
    endtask

    logic [31:0] bp_w[8] = '{32'h1000_0000, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
                             32'h4444_0004, 32'h5555_0005, 32'h6666_0006, 32'h7777_0007};
    int exp_cnt[15] = '{1, 1, 2, 3, 4, 3, 4, 4, 4, 3, 4, 4, 4, 3, 4};

    initial begin
        int e0, idx;
        logic acc;
        // asynchronous reset with no clock edge involved
        #1 rstn = 1'b0;
        #1;
        chk("rst_out_val", 32'(a_out_val), 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_count", 32'(a_count), 0);
        chk("rst_in_rdy", 32'(a_in_rdy), 1);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_b_in_rdy", 32'(b_in_rdy), 1);
        step(2);
        @(negedge clk) rstn = 1'b1;
        step(2);
        // single word latency and hold
        a_in_val = 1'b1;
        a_in_data = 32'hA5A5_0001;
        step();
        a_in_val = 1'b0;
        chk("single_count_E", 32'(a_count), 1);
        chk("single_val_E", 32'(a_out_val), 0);
        chk("single_busy_E", 32'(a_busy), 1);
        step();
        chk("single_val_E1", 32'(a_out_val), 1);
        chk("single_data_E1", a_out_data, 32'hA5A5_0001);
        chk("single_count_E1", 32'(a_count), 0);
        step();
        chk("single_val_E2", 32'(a_out_val), 0);
        chk("single_data_E2", a_out_data, 32'hA5A5_0001);
        step(2);
        chk("single_busy_E4", 32'(a_busy), 1);
        step();
        chk("single_busy_E5", 32'(a_busy), 0);
        chk("single_data_idle", a_out_data, 32'hA5A5_0001);
        // burst of 4 back-to-back
        qa_d.delete(); qa_c.delete();
        exp_q = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
        a_in_val = 1'b1;
        a_in_data = exp_q[0];
        step();
        e0 = cyc;
        chk("burst_cnt0", 32'(a_count), 1);
        chk("burst_rdy0", 32'(a_in_rdy), 1);
        a_in_data = exp_q[1];
        step();
        chk("burst_cnt1", 32'(a_count), 1);
        chk("burst_rdy1", 32'(a_in_rdy), 1);
        a_in_data = exp_q[2];
        step();
        chk("burst_cnt2", 32'(a_count), 2);
        chk("burst_rdy2", 32'(a_in_rdy), 1);
        a_in_data = exp_q[3];
        step();
        a_in_val = 1'b0;
        chk("burst_cnt3", 32'(a_count), 3);
        chk("burst_rdy3", 32'(a_in_rdy), 1);
        chk_pulses("burst", 1'b0, 4, e0 + 1);
        // backpressure: 8 words with in_val held high
        qa_d.delete(); qa_c.delete();
        exp_q.delete();
        foreach (bp_w[i]) exp_q.push_back(bp_w[i]);
        idx = 0;
        e0 = 0;
        a_in_val = 1'b1;
        a_in_data = bp_w[0];
        for (int i = 0; i < 15; i++) begin
            acc = a_in_rdy;
            step();
            if (i == 0) e0 = cyc;
            if (acc) idx++;
            a_in_val = idx < 8;
            a_in_data = idx < 8 ? bp_w[idx] : '0;
            chk($sformatf("bp_cnt%0d", i), 32'(a_count), exp_cnt[i]);
            chk($sformatf("bp_rdy%0d", i), 32'(a_in_rdy), 32'(exp_cnt[i] != 4));
        end
        a_in_val = 1'b0;
        chk("bp_accepted", idx, 8);
        chk_pulses("bp", 1'b0, 4, e0 + 1);
        // reset during HOLD with two words queued
        qa_d.delete(); qa_c.delete();
        a_in_val = 1'b1;
        a_in_data = 32'hC000_0000;
        step();
        a_in_data = 32'hC000_0001;
        step();
        a_in_data = 32'hC000_0002;
        step();
        a_in_val = 1'b0;
        chk("hold_count", 32'(a_count), 2);
        chk("hold_val", 32'(a_out_val), 0);
        chk("hold_data", a_out_data, 32'hC000_0000);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_val", 32'(a_out_val), 0);
        chk("midrst_data", a_out_data, 0);
        chk("midrst_count", 32'(a_count), 0);
        chk("midrst_rdy", 32'(a_in_rdy), 1);
        chk("midrst_busy", 32'(a_busy), 0);
        @(negedge clk) rstn = 1'b1;
        qa_d.delete(); qa_c.delete();
        step(12);
        chk("midrst_no_pulse", qa_d.size(), 0);
        chk("midrst_idle_busy", 32'(a_busy), 0);
        // reset while a pulse is high
        a_in_val = 1'b1;
        a_in_data = 32'hD000_0001;
        step();
        a_in_val = 1'b0;
        step();
        chk("pulse_high", 32'(a_out_val), 1);
        #2 rstn = 1'b0;
        #1;
        chk("pulse_drop_val", 32'(a_out_val), 0);
        chk("pulse_drop_data", a_out_data, 0);
        @(negedge clk) rstn = 1'b1;
        qa_d.delete(); qa_c.delete();
        step(10);
        chk("pulse_drop_no_pulse", qa_d.size(), 0);
        // DEPTH=2, GAP=1 sweep over 10 words
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(32'hE000_0000 + 32'(i * 17));
        idx = 0;
        e0 = 0;
        b_in_val = 1'b1;
        b_in_data = exp_q[0];
        for (int i = 0; i < 60 && idx < 10; i++) begin
            acc = b_in_rdy;
            step();
            if (i == 0) e0 = cyc;
            if (acc) idx++;
            b_in_val = idx < 10;
            b_in_data = idx < 10 ? exp_q[idx] : '0;
        end
        b_in_val = 1'b0;
        chk("sweep_accepted", idx, 10);
        chk_pulses("sweep", 1'b1, 2, e0 + 1);
        chk("sweep_idle_busy", 32'(b_busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
